// File: rtl/inst_mem_loadable.sv
// -----------------------------------------------------------------------------
// inst_mem_loadable
//
// Run-time loadable instruction memory for the IF stage. A byte-serial boot
// port assembles big-endian 32-bit words into the array. A registered fetch
// port with stall hold serves instructions once the image is loaded.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   load_start          : (re)start loading at word 0
//   load_valid/byte/last: byte stream, MSB-first within each word; load_last
//                         marks the final byte of the image
//   load_ready          : a byte presented this cycle is accepted
//   load_done           : one-cycle pulse in the first RUN cycle
//   loaded_words        : words written since the last load_start
//   fetch_req/addr      : byte-addressed fetch request (RUN only)
//   fetch_stall         : hold all fetch outputs and discard this request
//   fetch_valid         : instruction/fetch_err are meaningful
//   instruction         : fetched word (0 on error or when not valid)
//   fetch_err           : misaligned or out-of-range fetch
// -----------------------------------------------------------------------------
module inst_mem_loadable #(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = $clog2(DEPTH_WORDS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [CNT_W-1:0]  loaded_words,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_valid,
  output logic [31:0]       instruction,
  output logic              fetch_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] word_ptr_q, word_ptr_d;
  logic [31:0]      asm_q, asm_d;
  logic             load_done_q, load_done_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic [31:0]      instruction_q, instruction_d;
  logic             fetch_err_q, fetch_err_d;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic             mem_we;
  logic [31:0]      asm_merged;
  logic             byte_accept;
  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_bad;
  logic [31:0]      rd_word;

  // Every written word bumps word_ptr, so it doubles as the loaded-word count.
  assign loaded_words = word_ptr_q;
  assign load_ready   = (state_q == ST_LOAD) && (word_ptr_q < CNT_W'(DEPTH_WORDS));
  assign load_done    = load_done_q;
  assign fetch_valid  = fetch_valid_q;
  assign instruction  = instruction_q;
  assign fetch_err    = fetch_err_q;

  // A byte arriving with load_start belongs to the aborted load, not the new one.
  assign byte_accept = load_valid && load_ready && !load_start;

  assign fetch_idx = fetch_addr[IDX_W+1:2];
  assign fetch_bad = (|fetch_addr[1:0]) || (|fetch_addr[ADDR_W-1:IDX_W+2]);
  // Words past the current image read as NOP even if stale data remains.
  assign rd_word   = (CNT_W'(fetch_idx) < word_ptr_q) ? mem_q[fetch_idx] : 32'd0;

  // Drop the incoming byte into its big-endian lane. Lanes not yet filled
  // stay zero because asm_q is cleared at every word boundary, which also
  // provides the zero padding for a short final word.
  always_comb begin
    asm_merged = asm_q;
    unique case (byte_cnt_q)
      2'd0: asm_merged[31:24] = load_byte;
      2'd1: asm_merged[23:16] = load_byte;
      2'd2: asm_merged[15:8]  = load_byte;
      2'd3: asm_merged[7:0]   = load_byte;
      default: asm_merged = asm_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    word_ptr_d    = word_ptr_q;
    asm_d         = asm_q;
    mem_we        = 1'b0;
    fetch_valid_d = fetch_valid_q;
    instruction_d = instruction_q;
    fetch_err_d   = fetch_err_q;

    if (load_start) begin
      // Same restart from any state; a partial word is simply discarded.
      state_d    = ST_LOAD;
      byte_cnt_d = 2'd0;
      word_ptr_d = '0;
      asm_d      = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_LOAD: begin
          if (byte_accept) begin
            if (load_last || (byte_cnt_q == 2'd3)) begin
              mem_we     = 1'b1;
              asm_d      = '0;
              byte_cnt_d = 2'd0;
              word_ptr_d = word_ptr_q + CNT_W'(1);
              if (load_last || (word_ptr_q == CNT_W'(DEPTH_WORDS - 1))) begin
                state_d = ST_RUN;
              end
            end else begin
              asm_d      = asm_merged;
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end

    load_done_d = (state_d == ST_RUN) && (state_q != ST_RUN);

    // Fetch port: load_start beats everything, then stall holds, then a new request.
    if ((state_q != ST_RUN) || load_start) begin
      fetch_valid_d = 1'b0;
      instruction_d = 32'd0;
      fetch_err_d   = 1'b0;
    end else if (fetch_stall) begin
      fetch_valid_d = fetch_valid_q;
      instruction_d = instruction_q;
      fetch_err_d   = fetch_err_q;
    end else if (fetch_req) begin
      fetch_valid_d = 1'b1;
      instruction_d = fetch_bad ? 32'd0 : rd_word;
      fetch_err_d   = fetch_bad;
    end else begin
      fetch_valid_d = 1'b0;
      instruction_d = 32'd0;
      fetch_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= 2'd0;
      word_ptr_q    <= '0;
      asm_q         <= '0;
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      instruction_q <= 32'd0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      word_ptr_q    <= word_ptr_d;
      asm_q         <= asm_d;
      load_done_q   <= load_done_d;
      fetch_valid_q <= fetch_valid_d;
      instruction_q <= instruction_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  // Array contents survive reset; loaded_words gates visibility instead.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[word_ptr_q[IDX_W-1:0]] <= asm_merged;
    end
  end

endmodule

// File: tb/tb_inst_mem_loadable.sv
module tb_inst_mem_loadable;

  localparam int D      = 128;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = $clog2(D + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic              load_start, load_valid, load_last;
  logic [7:0]        load_byte;
  logic              load_ready, load_done;
  logic [CNT_W-1:0]  loaded_words;
  logic              fetch_req, fetch_stall;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid, fetch_err;
  logic [31:0]       instruction;

  int checks = 0;
  int errors = 0;

  inst_mem_loadable #(.DEPTH_WORDS(D), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .loaded_words(loaded_words),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .instruction(instruction), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The image is kept as a flat byte array; words are read out big-endian.
  // mode: 0 idle, 1 loading, 2 running.
  logic [7:0]  img [4*D];
  int          m_mode, m_nbytes, m_lw;
  logic        e_valid, e_err, e_done;
  logic [31:0] e_instr;

  function automatic logic [31:0] img_word(input int idx);
    return {img[4*idx], img[4*idx+1], img[4*idx+2], img[4*idx+3]};
  endfunction

  task automatic model_restart();
    m_mode   = 1;
    m_nbytes = 0;
    m_lw     = 0;
    for (int i = 0; i < 4*D; i++) img[i] = 8'h00;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_nbytes = 0; m_lw = 0;
      e_valid = 1'b0; e_err = 1'b0; e_instr = 32'd0; e_done = 1'b0;
    end else begin
      if (m_mode != 2 || load_start) begin
        e_valid = 1'b0; e_err = 1'b0; e_instr = 32'd0;
      end else if (fetch_stall) begin
        e_valid = e_valid;
      end else if (fetch_req) begin
        e_valid = 1'b1;
        e_err   = (fetch_addr % 4 != 0) || (fetch_addr >= 4*D);
        if (e_err) e_instr = 32'd0;
        else if (int'(fetch_addr / 4) < m_lw) e_instr = img_word(int'(fetch_addr / 4));
        else e_instr = 32'd0;
      end else begin
        e_valid = 1'b0; e_err = 1'b0; e_instr = 32'd0;
      end
      e_done = 1'b0;
      if (load_start) begin
        model_restart();
      end else if (m_mode == 1 && load_valid) begin
        img[m_nbytes] = load_byte;
        m_nbytes++;
        if (load_last) begin
          m_lw = (m_nbytes + 3) / 4;
          m_mode = 2; e_done = 1'b1;
        end else if (m_nbytes % 4 == 0) begin
          m_lw = m_nbytes / 4;
          if (m_lw == D) begin m_mode = 2; e_done = 1'b1; end
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clock) begin
    check("load_ready",   32'(load_ready),   32'(m_mode == 1 && m_lw < D));
    check("load_done",    32'(load_done),    32'(e_done));
    check("loaded_words", 32'(loaded_words), 32'(m_lw));
    check("fetch_valid",  32'(fetch_valid),  32'(e_valid));
    check("fetch_err",    32'(fetch_err),    32'(e_err));
    check("instruction",  instruction,       e_instr);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1; tick(); load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    load_valid = 1'b1; load_byte = b; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a; tick(); fetch_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog1 [8];
    prog1 = '{8'h80, 8'h01, 8'h06, 8'h0A, 8'h04, 8'h01, 8'h10, 8'h00};
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_byte = 8'h00; fetch_req = 1'b0; fetch_stall = 1'b0; fetch_addr = '0;
    repeat (3) tick();
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    reset = 1'b0;
    fetch(32'h0);
    check("idle_fetch_ignored", 32'(fetch_valid), 32'd0);

    // Two-word image.
    start_load();
    check("ready_after_start", 32'(load_ready), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog1[i], i == 7);
    check("lw_two", 32'(loaded_words), 32'd2);
    check("done_pulse", 32'(load_done), 32'd1);
    fetch(32'h0);
    check("word0", instruction, 32'h8001060A);
    check("done_gone", 32'(load_done), 32'd0);
    fetch(32'h4);
    check("word1", instruction, 32'h04011000);
    fetch(32'h8);
    check("beyond_instr", instruction, 32'd0);
    check("beyond_err", 32'(fetch_err), 32'd0);
    check("beyond_valid", 32'(fetch_valid), 32'd1);
    fetch(32'h2);
    check("misalign_err", 32'(fetch_err), 32'd1);
    check("misalign_valid", 32'(fetch_valid), 32'd1);
    fetch(4*D);
    check("range_err", 32'(fetch_err), 32'd1);
    check("range_instr", instruction, 32'd0);

    // Stall holds the previous result.
    fetch(32'h0);
    fetch_stall = 1'b1; fetch(32'h4);
    check("stall_hold", instruction, 32'h8001060A);
    tick();
    check("stall_hold2", instruction, 32'h8001060A);
    fetch_stall = 1'b0; fetch(32'h4);
    check("after_stall", instruction, 32'h04011000);
    tick();
    check("no_req_valid", 32'(fetch_valid), 32'd0);

    // load_start beats a simultaneous fetch; then a short 3-byte image.
    fetch_req = 1'b1; fetch_addr = 32'h0; start_load(); fetch_req = 1'b0;
    check("start_wins_valid", 32'(fetch_valid), 32'd0);
    check("start_clears_lw", 32'(loaded_words), 32'd0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b1);
    check("lw_one", 32'(loaded_words), 32'd1);
    fetch(32'h0);
    check("padded_word", instruction, 32'hAABBCC00);
    fetch(32'h4);
    check("stale_hidden", instruction, 32'd0);

    // Overfill: 4*D+2 bytes with no load_last.
    start_load();
    for (int i = 0; i < 4*D + 2; i++) begin
      send_byte(8'(i), 1'b0);
      if (i == 4*D - 1) begin
        check("full_done", 32'(load_done), 32'd1);
        check("full_ready", 32'(load_ready), 32'd0);
      end
    end
    check("full_lw", 32'(loaded_words), 32'(D));
    fetch(32'h0);
    check("full_first", instruction, 32'h00010203);
    fetch(4*(D-1));
    check("full_last", instruction, 32'hFCFDFEFF);

    // Reset in the middle of a load.
    start_load();
    for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), 1'b0);
    reset = 1'b1; #1;
    check("midrst_lw", 32'(loaded_words), 32'd0);
    check("midrst_ready", 32'(load_ready), 32'd0);
    tick(); reset = 1'b0;
    start_load();
    send_byte(8'h21, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b0); send_byte(8'h24, 1'b0);
    send_byte(8'h25, 1'b1);
    check("reload_lw", 32'(loaded_words), 32'd2);
    fetch(32'h0);
    check("reload_w0", instruction, 32'h21222324);
    fetch(32'h4);
    check("reload_w1", instruction, 32'h25000000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
